// File: rtl/vc_allocator.sv
// Virtual-channel allocator: per output port, grants one requesting input VC a free downstream VC.
// Arbitration is fixed priority by default; define VC_ALLOC_RR_EN for per-output round-robin.
module vc_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2,
  localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int PORT_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic                                          rst,
  input  logic                                          clk,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0]   out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               idle_downstream_vc_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]               grant_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]  vc_new_o,
  output logic                                          error_o
);

  localparam int REQ_NUM = PORT_NUM * VC_NUM;
  localparam int IDX_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]   avail;
  logic [PORT_NUM-1:0][VC_NUM-1:0]   granted;
  logic [PORT_NUM-1:0][REQ_NUM-1:0]  cand;
  logic [PORT_NUM-1:0]               win_valid;
  logic [PORT_NUM-1:0][IDX_W-1:0]    win_idx;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]  free_vc;
  logic                              error_next;

`ifdef VC_ALLOC_RR_EN
  logic [PORT_NUM-1:0][IDX_W-1:0]    rr;
`endif

  // Per-output arbitration: a two-pass scan from the priority start index wraps around the requesters.
  always_comb begin
    int start;
    start     = 0;
    cand      = '0;
    win_valid = '0;
    win_idx   = '0;
    free_vc   = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int w = VC_NUM - 1; w >= 0; w--) begin
        if (avail[o][w]) free_vc[o] = VC_SIZE'(w);
      end
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          cand[o][p*VC_NUM+v] = request_i[p][v] && (int'(out_port_i[p][v]) == o);
        end
      end
`ifdef VC_ALLOC_RR_EN
      start = int'(rr[o]);
`else
      start = 0;
`endif
      for (int r = 0; r < REQ_NUM; r++) begin
        if (!win_valid[o] && cand[o][r] && (r >= start)) begin
          win_valid[o] = 1'b1;
          win_idx[o]   = IDX_W'(r);
        end
      end
      for (int r = 0; r < REQ_NUM; r++) begin
        if (!win_valid[o] && cand[o][r] && (r < start)) begin
          win_valid[o] = 1'b1;
          win_idx[o]   = IDX_W'(r);
        end
      end
      if (rst || (avail[o] == '0)) win_valid[o] = 1'b0;
    end
  end

  always_comb begin
    grant_o  = '0;
    vc_new_o = '0;
    granted  = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int w = 0; w < VC_NUM; w++) begin
        granted[o][w] = win_valid[o] && (free_vc[o] == VC_SIZE'(w));
      end
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          if (win_valid[o] && (win_idx[o] == IDX_W'(p*VC_NUM+v))) begin
            grant_o[p][v]  = 1'b1;
            vc_new_o[p][v] = free_vc[o];
          end
        end
      end
    end
  end

  // Protocol errors: releasing a VC that is already free, or requesting a nonexistent output.
  always_comb begin
    error_next = |(idle_downstream_vc_i & avail);
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (request_i[p][v] && (int'(out_port_i[p][v]) >= PORT_NUM)) error_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avail   <= '1;
      error_o <= 1'b0;
    end else begin
      avail   <= (avail & ~granted) | idle_downstream_vc_i;
      error_o <= error_next;
    end
  end

`ifdef VC_ALLOC_RR_EN
  // After a grant, the requester just past the winner gets top priority on that output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= '0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        if (win_valid[o]) begin
          rr[o] <= (int'(win_idx[o]) == REQ_NUM - 1) ? '0 : win_idx[o] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_allocator.sv
// Testbench for vc_allocator: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based allocation model.
module tb_vc_allocator;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_SIZE  = 1;
  localparam int PORT_W   = 3;
  localparam int REQ_NUM  = PORT_NUM * VC_NUM;

  localparam logic [PORT_W-1:0] LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] NORTH = 3'd1;
  localparam logic [PORT_W-1:0] SOUTH = 3'd2;
  localparam logic [PORT_W-1:0] WEST  = 3'd3;
  localparam logic [PORT_W-1:0] EAST  = 3'd4;

  logic clk;
  logic rst;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              request_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0]  out_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              idle_downstream_vc_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              grant_o;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o;
  logic                                         error_o;

  int checks = 0;
  int passes = 0;

  bit m_avail [PORT_NUM][VC_NUM];
  int m_rr    [PORT_NUM];
  bit m_err;

  vc_allocator #(.PORT_NUM(PORT_NUM), .VC_NUM(VC_NUM)) dut (
    .rst                  (rst),
    .clk                  (clk),
    .request_i            (request_i),
    .out_port_i           (out_port_i),
    .idle_downstream_vc_i (idle_downstream_vc_i),
    .grant_o              (grant_o),
    .vc_new_o             (vc_new_o),
    .error_o              (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  function automatic int g(input int p, input int v);
    return int'(grant_o >> (p*VC_NUM + v)) & 1;
  endfunction

  function automatic int vcn(input int p, input int v);
    return int'(vc_new_o >> ((p*VC_NUM + v)*VC_SIZE)) & ((1 << VC_SIZE) - 1);
  endfunction

  task automatic model_reset();
    for (int o = 0; o < PORT_NUM; o++) begin
      m_rr[o] = 0;
      for (int w = 0; w < VC_NUM; w++) m_avail[o][w] = 1'b1;
    end
    m_err = 1'b0;
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    request_i            = '0;
    out_port_i           = '0;
    idle_downstream_vc_i = '0;
  endtask

  task automatic apply_stimulus();
    begin_cycle();
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        request_i[p][v] = ($urandom_range(0, 2) != 0);
        out_port_i[p][v] = ($urandom_range(0, 15) == 0) ? PORT_W'($urandom_range(5, 7))
                                                          : PORT_W'($urandom_range(0, 4));
        idle_downstream_vc_i[p][v] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  // Reference model: candidates per output gathered into a queue, winner picked by rule, lowest free VC assigned.
  initial begin
    bit exp_grant [PORT_NUM][VC_NUM];
    int exp_vc    [PORT_NUM][VC_NUM];
    bit nxt_avail [PORT_NUM][VC_NUM];
    int nxt_rr    [PORT_NUM];
    bit nxt_err;
    int cands[$];
    int frees[$];
    int best;
    int best_dist;
    logic [PORT_NUM-1:0][VC_NUM-1:0] exp_vec;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        check_output("grant_in_reset", int'(grant_o), 0);
        check_output("error_in_reset", int'(error_o), 0);
      end else begin
        nxt_avail = m_avail;
        nxt_rr    = m_rr;
        nxt_err   = 1'b0;
        for (int p = 0; p < PORT_NUM; p++) begin
          for (int v = 0; v < VC_NUM; v++) begin
            exp_grant[p][v] = 1'b0;
            exp_vc[p][v]    = 0;
          end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
          cands.delete();
          frees.delete();
          for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
              if (request_i[p][v] && int'(out_port_i[p][v]) == o) cands.push_back(p*VC_NUM + v);
            end
          end
          for (int w = 0; w < VC_NUM; w++) if (m_avail[o][w]) frees.push_back(w);
          if (cands.size() > 0 && frees.size() > 0) begin
            best = cands[0];
`ifdef VC_ALLOC_RR_EN
            best_dist = REQ_NUM;
            foreach (cands[i]) begin
              if ((cands[i] - m_rr[o] + REQ_NUM) % REQ_NUM < best_dist) begin
                best      = cands[i];
                best_dist = (cands[i] - m_rr[o] + REQ_NUM) % REQ_NUM;
              end
            end
            nxt_rr[o] = (best + 1) % REQ_NUM;
`else
            best_dist = 0;
`endif
            exp_grant[best / VC_NUM][best % VC_NUM] = 1'b1;
            exp_vc[best / VC_NUM][best % VC_NUM]    = frees[0];
            nxt_avail[o][frees[0]] = 1'b0;
          end
        end
        for (int p = 0; p < PORT_NUM; p++) begin
          for (int v = 0; v < VC_NUM; v++) begin
            if (idle_downstream_vc_i[p][v]) begin
              if (m_avail[p][v]) nxt_err = 1'b1;
              nxt_avail[p][v] = 1'b1;
            end
            if (request_i[p][v] && int'(out_port_i[p][v]) >= PORT_NUM) nxt_err = 1'b1;
            exp_vec[p][v] = exp_grant[p][v];
          end
        end
        check_output("grant_vec", int'(grant_o), int'(exp_vec));
        check_output("error", int'(error_o), int'(m_err));
        for (int p = 0; p < PORT_NUM; p++) begin
          for (int v = 0; v < VC_NUM; v++) begin
            if (exp_grant[p][v]) check_output($sformatf("vc_new[%0d][%0d]", p, v), vcn(p, v), exp_vc[p][v]);
          end
        end
        @(posedge clk);
        if (!rst) begin
          m_avail = nxt_avail;
          m_rr    = nxt_rr;
          m_err   = nxt_err;
        end
      end
    end
  end

  initial begin
    rst                  = 1'b1;
    request_i            = '0;
    out_port_i           = '0;
    idle_downstream_vc_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #3 check_output("error_after_reset", int'(error_o), 0);

    // Single request to EAST, then a second takes VC 1, a third stalls until both are released.
    begin_cycle();
    request_i[1][0] = 1'b1; out_port_i[1][0] = EAST;
    #3;
    check_output("east_grant", g(1, 0), 1);
    check_output("east_vc0", vcn(1, 0), 0);
    begin_cycle();
    request_i[2][0] = 1'b1; out_port_i[2][0] = EAST;
    #3;
    check_output("east_second_grant", g(2, 0), 1);
    check_output("east_second_vc1", vcn(2, 0), 1);
    begin_cycle();
    request_i[3][0] = 1'b1; out_port_i[3][0] = EAST;
    idle_downstream_vc_i[EAST] = 2'b11;
    #3;
    check_output("east_full_stall", g(3, 0), 0);
    begin_cycle();
    request_i[3][0] = 1'b1; out_port_i[3][0] = EAST;
    #3;
    check_output("east_after_release", g(3, 0), 1);
    check_output("east_after_release_vc", vcn(3, 0), 0);
    check_output("no_error_on_valid_release", int'(error_o), 0);
    begin_cycle();
    idle_downstream_vc_i[EAST] = 2'b01;

    // Three requesters on NORTH: two served, third waits for a release.
    begin_cycle();
    request_i[0][0] = 1'b1; out_port_i[0][0] = NORTH;
    request_i[2][1] = 1'b1; out_port_i[2][1] = NORTH;
    request_i[3][0] = 1'b1; out_port_i[3][0] = NORTH;
    #3;
    check_output("north_c1_winner", g(0, 0), 1);
    check_output("north_c1_vc", vcn(0, 0), 0);
    check_output("north_c1_single", int'(grant_o), 1);
    begin_cycle();
    request_i[2][1] = 1'b1; out_port_i[2][1] = NORTH;
    request_i[3][0] = 1'b1; out_port_i[3][0] = NORTH;
    #3;
    check_output("north_c2_winner", g(2, 1), 1);
    check_output("north_c2_vc", vcn(2, 1), 1);
    check_output("north_c2_loser", g(3, 0), 0);
    begin_cycle();
    request_i[3][0] = 1'b1; out_port_i[3][0] = NORTH;
    idle_downstream_vc_i[NORTH] = 2'b01;
    #3;
    check_output("north_c3_stall", g(3, 0), 0);
    begin_cycle();
    request_i[3][0] = 1'b1; out_port_i[3][0] = NORTH;
    #3;
    check_output("north_c4_grant", g(3, 0), 1);
    check_output("north_c4_vc", vcn(3, 0), 0);
    begin_cycle();
    idle_downstream_vc_i[NORTH] = 2'b11;

    // Independent outputs granted in the same cycle.
    begin_cycle();
    request_i[0][1] = 1'b1; out_port_i[0][1] = LOCAL;
    request_i[4][0] = 1'b1; out_port_i[4][0] = SOUTH;
    #3;
    check_output("local_grant", g(0, 1), 1);
    check_output("south_grant", g(4, 0), 1);
    check_output("local_vc", vcn(0, 1), 0);
    check_output("south_vc", vcn(4, 0), 0);
    begin_cycle();
    idle_downstream_vc_i[LOCAL] = 2'b01;
    idle_downstream_vc_i[SOUTH] = 2'b01;

    // Two inputs contend for WEST every cycle while the previous grant's VC is recycled.
    for (int c = 0; c < 5; c++) begin
      begin_cycle();
      if (c < 4) begin
        request_i[0][0] = 1'b1; out_port_i[0][0] = WEST;
        request_i[1][0] = 1'b1; out_port_i[1][0] = WEST;
      end
      if (c > 0) idle_downstream_vc_i[WEST] = (c % 2 == 1) ? 2'b01 : 2'b10;
      #3;
      if (c < 4) begin
`ifdef VC_ALLOC_RR_EN
        check_output($sformatf("west_c%0d_in0", c), g(0, 0), (c % 2 == 0) ? 1 : 0);
        check_output($sformatf("west_c%0d_in1", c), g(1, 0), (c % 2 == 1) ? 1 : 0);
        check_output($sformatf("west_c%0d_vc", c), (c % 2 == 0) ? vcn(0, 0) : vcn(1, 0), c % 2);
`else
        check_output($sformatf("west_c%0d_in0", c), g(0, 0), 1);
        check_output($sformatf("west_c%0d_in1", c), g(1, 0), 0);
        check_output($sformatf("west_c%0d_vc", c), vcn(0, 0), c % 2);
`endif
      end
    end

    // Releasing a free VC and requesting a nonexistent port both raise a one-cycle error.
    begin_cycle();
    idle_downstream_vc_i[SOUTH] = 2'b10;
    begin_cycle();
    #3 check_output("double_release_error", int'(error_o), 1);
    begin_cycle();
    request_i[0][0] = 1'b1; out_port_i[0][0] = 3'd6;
    #3;
    check_output("error_one_cycle", int'(error_o), 0);
    check_output("invalid_port_no_grant", g(0, 0), 0);
    begin_cycle();
    #3 check_output("invalid_port_error", int'(error_o), 1);

    // Fill every downstream VC, then reset with an error flag and a stalled request pending.
    for (int c = 0; c < 2; c++) begin
      begin_cycle();
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          request_i[p][v]  = 1'b1;
          out_port_i[p][v] = PORT_W'(p);
        end
      end
    end
    begin_cycle();
    request_i[0][0] = 1'b1; out_port_i[0][0] = 3'd7;
    request_i[1][0] = 1'b1; out_port_i[1][0] = EAST;
    #3 check_output("full_east_stall", g(1, 0), 0);
    @(posedge clk);
    #1;
    check_output("error_before_reset", int'(error_o), 1);
    rst                  = 1'b1;
    request_i            = '0;
    out_port_i           = '0;
    idle_downstream_vc_i = '0;
    request_i[1][0]      = 1'b1;
    out_port_i[1][0]     = EAST;
    #1;
    check_output("reset_clears_error", int'(error_o), 0);
    check_output("reset_blocks_grant", int'(grant_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    check_output("post_reset_grant", g(1, 0), 1);
    check_output("post_reset_vc", vcn(1, 0), 0);
    check_output("post_reset_error", int'(error_o), 0);

    for (int c = 0; c < 3000; c++) begin
      apply_stimulus();
      if (c == 1500) rst = 1'b1;
      if (c == 1503) rst = 1'b0;
    end

    begin_cycle();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vc_allocator.md
VC_ALLOCATOR -- requirements
Module: vc_allocator

Interface
REQ-001 Parameter PORT_NUM, default 5, meaning number of router ports (LOCAL, NORTH, SOUTH, WEST, EAST), which equals the number of input and output ports.
REQ-002 Parameter VC_NUM, default 2 (2**VC_SIZE from noc_pkg), meaning virtual channels per port.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 clk  input  1  clock.
REQ-005 request_i  input  [PORT_NUM-1:0][VC_NUM-1:0]  VA request from each input buffer (input port p, VC v).
REQ-006 out_port_i  input  [PORT_NUM-1:0][VC_NUM-1:0] port_t  requested output port per input VC; valid while request_i is high.
REQ-007 idle_downstream_vc_i  input  [PORT_NUM-1:0][VC_NUM-1:0]  one-cycle pulse from the downstream router on output port o: VC v is released.
REQ-008 grant_o  output  [PORT_NUM-1:0][VC_NUM-1:0]  combinational; VA granted to input (p,v); drives the buffer's vc_valid_i.
REQ-009 vc_new_o  output  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]  combinational; downstream VC assigned to input (p,v); meaningful only when grant_o is high.
REQ-010 error_o  output  1  registered protocol-error flag.

Function
REQ-011 State: avail[o][w] (1 = downstream VC w on output o is free), and, with VC_ALLOC_RR_EN, a per-output round-robin pointer rr[o] of width clog2(PORT_NUM*VC_NUM).
REQ-012 Requester index r = p*VC_NUM + v; request (p,v) targets output o when request_i[p][v] is high and out_port_i[p][v] == o.
REQ-013 Per output o per cycle: at most one winner, selected only when at least one avail[o][w] is high.
REQ-014 The winner is assigned the lowest-index w with avail[o][w] high.
REQ-015 Grant latency is zero: grant_o and vc_new_o are asserted in the cycle the request is sampled with resources free.
REQ-016 A request that is not granted is not latched; the requester holds request_i until granted.
REQ-017 Different outputs are granted independently in the same cycle, up to PORT_NUM grants per cycle.
REQ-018 Availability update on the clock edge: avail_next[o][w] = (avail[o][w] & ~granted[o][w]) | idle_downstream_vc_i[o][w].
REQ-019 A release pulse takes effect from the next cycle; a VC freed in cycle N is grantable no earlier than cycle N+1.
REQ-020 error_o is set for one cycle after any of:
- release of a VC whose avail bit is already 1;
- a request whose out_port_i is outside 0..PORT_NUM-1.
REQ-021 error_o is cleared otherwise; an invalid-port request is never granted.
REQ-022 All requests busy on an output with no free VC: no grant, no state change, no error.

Reset
REQ-023 On rst assertion, immediately (asynchronously): avail = all ones, rr = 0, error_o = 0.
REQ-024 grant_o is 0 while rst is high.
REQ-025 A grant pending at reset assertion is discarded; the VC stays free.

Configuration
REQ-026 Macro VC_ALLOC_RR_EN.
REQ-027 Defined: per output, fair round-robin. Priority starts at index rr[o]; after a grant, rr[o] = winner index + 1 (mod PORT_NUM*VC_NUM), else unchanged.
REQ-028 Undefined: fixed priority (lowest r wins); no rr registers are instantiated.

Verification
REQ-029 After reset, request_i[1][0]=1 with out_port_i=EAST -> grant_o[1][0]=1 same cycle, vc_new_o[1][0]=0, avail[EAST]=2'b10 next cycle.
REQ-030 Three inputs (0,0),(2,1),(3,0) request NORTH simultaneously with VC_NUM=2 -> two grants in cycles 1-2 (VCs 0,1), third stalls; idle_downstream_vc_i[NORTH][0] pulse -> third granted VC 0 one cycle later.
REQ-031 With VC_ALLOC_RR_EN, inputs (0,0) and (1,0) request WEST continuously and VCs are freed every cycle -> grants alternate 0,1,0,1; without the macro -> (0,0) wins every cycle.
REQ-032 Requests to LOCAL and SOUTH in the same cycle -> both granted VC 0 in that cycle.
REQ-033 Release pulse on an already-free VC -> error_o=1 for exactly one cycle, avail unchanged.
REQ-034 Assert rst mid-stream with all VCs allocated -> avail all ones and error_o=0 immediately; a new request is granted in the first cycle after rst deasserts.
